i2c_slave_regfile: RTL and testbench
====================================

# i2c_slave_regfile

Synthesizable I2C slave with an internal byte-wide register file. It sits on the bus side of the pad interface, downstream of the Wishbone I2C master's SCL/SDA pads, and gives the master a real target to address, write and read back. It samples the open-drain lines and drives SDA low only for ACK and read-data bits. SCL is never driven; there is no clock stretching.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit bus address the block responds to.
- NUM_REGS, 16, number of 8-bit registers; power of two, 2..256.
- FILTER_LEN, 3, consecutive equal samples required before a filtered line changes; range 1..8.

- CLK_I  in  1  system clock; all logic runs on the rising edge.
- ARST_N_I  in  1  asynchronous, active-low reset.
- SCL_PAD_I  in  1  resolved SCL bus level.
- SDA_PAD_I  in  1  resolved SDA bus level.
- SDA_PAD_O  out  1  constant 0; open-drain data value.
- SDA_PADOEN_O  out  1  SDA output enable, active low: 0 pulls SDA low, 1 releases it.
- BUSY_O  out  1  high from a detected START until a detected STOP.
- WR_STB_O  out  1  one-cycle pulse for each register write.
- WR_ADDR_O  out  8  register index written; valid with WR_STB_O.
- WR_DATA_O  out  8  byte written; valid with WR_STB_O.

## Operation
- **Input conditioning.** Each pad passes through a 2-flop synchronizer and then the glitch filter. The filtered level toggles only after FILTER_LEN consecutive samples that differ from it.
- **Edge and condition detection.** Edges are taken from the filtered signals.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Bit transfer.** Data is MSB first. SDA is sampled on SCL rising; the block drives SDA on SCL falling.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, WAIT.
- **Bus conditions.**
  - START in any state goes to ADDR. This includes repeated START. The bit counter clears and SDA is released.
  - STOP in any state goes to IDLE and releases SDA. The pointer is kept.
- **ADDR.** Collects 8 bits.
  - Bits [7:1] equal to SLAVE_ADDR: go to ADDR_ACK.
  - Mismatch: go to WAIT with SDA released. WAIT is left only on START or STOP.
- **ADDR_ACK.**
  - On the SCL falling edge after bit 8, drive SDA low.
  - On the next falling edge, release SDA.
  - R/W=0: go to PTR.
  - R/W=1: load reg[ptr] into the shift register, drive its MSB on that same falling edge, and go to RDATA.
- **PTR.** The first write byte sets ptr = byte mod NUM_REGS. ACK is given via PTR_ACK, then the block enters WDATA.
- **WDATA.** Each subsequent byte is handled in WDATA_ACK:
  - ACK is driven.
  - reg[ptr] is written on the same cycle the ACK drive begins.
  - WR_STB_O pulses with WR_ADDR_O = ptr and WR_DATA_O = byte.
  - ptr increments modulo NUM_REGS (wraps NUM_REGS-1 -> 0).
- **RDATA.**
  - After 8 bits, release SDA on the falling edge and enter RDATA_MACK.
  - Sample the master's ACK on SCL rising.
  - ACK (0): ptr increments, load the next register, drive its MSB on the next falling edge, back to RDATA.
  - NACK (1): ptr increments, go to WAIT.
- **Pointer on read.** The pointer advances once per byte transferred, ACKed or NACKed.
- **Reset values.**
  - All registers 0x00, ptr 0, state IDLE.
  - SDA_PADOEN_O=1, SDA_PAD_O=0, BUSY_O=0, WR_STB_O=0, WR_ADDR_O=0, WR_DATA_O=0.
- **Reset mid-transfer.** The line is released immediately, asynchronously. The block ignores the bus until the next START.

## Timing
- Pad to filtered-signal latency: 2 + FILTER_LEN cycles.
- SDA_PADOEN_O changes 1 cycle after a filtered SCL falling edge is detected. That is 3 + FILTER_LEN CLK_I cycles after the pad edge, which meets tHD;DAT.
- Minimum CLK_I frequency: 16 × SCL frequency. At FILTER_LEN=3 the bound is 400 kHz SCL with CLK_I ≥ 6.4 MHz.
- BUSY_O rises 1 cycle after START detection and falls 1 cycle after STOP detection.
- WR_STB_O is exactly one cycle wide and never fires twice per byte.
- START and STOP detection take priority over a data edge seen in the same cycle.

## Structure
- **Package i2c_slave_pkg** holds:
  - the state enum `i2c_slv_state_t`;
  - the ACK/NACK level constants;
  - the bit-count width constant.
- **Sub-module i2c_pad_filter** (parameter FILTER_LEN) contains the synchronizer plus glitch filter. It is instantiated once for SCL and once for SDA.
- The register file is a flop array inside the top module; NUM_REGS is small, so no RAM macro is used.

## Test plan
- **Write then read back.** Master writes addr 0xA0, ptr 0x03, data 0x5A, 0xC3, then STOP.
  - Required: ACK on all 4 bytes.
  - WR_STB_O pulses with (0x03,0x5A) then (0x04,0xC3).
  - A read of 0xA1 at ptr 3 returns 0x5A then 0xC3.
- **Address mismatch.** Master sends 0xA2.
  - Required: NACK (SDA_PADOEN_O stays 1 throughout), no WR_STB_O.
  - The next START to 0xA0 is ACKed.
- **Wrap-around.** Set ptr 0x0F and write 0x11, 0x22.
  - Required: reg[15]=0x11, reg[0]=0x22, WR_ADDR_O sequence 0x0F, 0x00.
- **Repeated START read.** Write ptr 0x05, repeated START, read 3 bytes with ACK, ACK, NACK.
  - Required: returns reg[5..7].
  - SDA is released after the NACK; BUSY_O stays 1 until STOP.
- **Glitch and reset.**
  - A 2-cycle SDA low pulse while SCL is high (FILTER_LEN=3) must not be detected as START.
  - Asserting ARST_N_I during a read-data bit releases SDA immediately and clears every register to 0x00.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-file slave.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ADDR       = 4'd1,
    ST_ADDR_ACK   = 4'd2,
    ST_PTR        = 4'd3,
    ST_PTR_ACK    = 4'd4,
    ST_WDATA      = 4'd5,
    ST_WDATA_ACK  = 4'd6,
    ST_RDATA      = 4'd7,
    ST_RDATA_MACK = 4'd8,
    ST_WAIT       = 4'd9
  } i2c_slv_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Wide enough to count the 8 data bits plus the ninth (ACK) slot.
  localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/i2c_pad_filter.sv
// Two-flop synchronizer followed by a majority-free run-length glitch filter.
module i2c_pad_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic pad_i,
  output logic filt_o
);

  logic [1:0] sync_q;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;

  // Run-length counter: the filtered level flips after FILTER_LEN differing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = 4'd0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == 4'(FILTER_LEN - 1)) begin
        filt_d = ~filt_q;
        cnt_d  = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      cnt_d = 4'd0;
    end
  end

  // Synchronizer and filter state; idle bus level is high.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= 4'd0;
    end else begin
      sync_q <= {sync_q[0], pad_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a byte-wide register file with an auto-incrementing pointer.
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 3
) (
  input  logic       CLK_I,
  input  logic       ARST_N_I,
  input  logic       SCL_PAD_I,
  input  logic       SDA_PAD_I,
  output logic       SDA_PAD_O,
  output logic       SDA_PADOEN_O,
  output logic       BUSY_O,
  output logic       WR_STB_O,
  output logic [7:0] WR_ADDR_O,
  output logic [7:0] WR_DATA_O
);

  localparam int PTR_W = $clog2(NUM_REGS);

  logic scl_f, sda_f;
  logic scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  i2c_slv_state_t        state_q, state_d;
  logic [BIT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]            sr_q, sr_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  rw_q, rw_d;
  logic                  phase_q, phase_d;
  logic                  oen_q, oen_d;
  logic                  busy_q, busy_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [7:0]            wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic [7:0]            regs_q [NUM_REGS];
  logic [7:0]            regs_d [NUM_REGS];

  logic [7:0] byte_in;
  logic [7:0] rd_byte;
  logic       last_bit;
  logic       addr_match;

  i2c_pad_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i (CLK_I),
    .rst_n (ARST_N_I),
    .pad_i (SCL_PAD_I),
    .filt_o(scl_f)
  );

  i2c_pad_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i (CLK_I),
    .rst_n (ARST_N_I),
    .pad_i (SDA_PAD_I),
    .filt_o(sda_f)
  );

  assign scl_rise   = scl_f & ~scl_prev_q;
  assign scl_fall   = ~scl_f & scl_prev_q;
  assign start_det  = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det   = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
  assign byte_in    = {sr_q[6:0], sda_f};
  assign rd_byte    = regs_q[ptr_q];
  assign last_bit   = (cnt_q == BIT_CNT_W'(7));
  assign addr_match = (sr_q[6:0] == SLAVE_ADDR);

  // Next-state, shift/pointer and SDA drive decisions; bus conditions override bit handling.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    phase_d   = phase_q;
    oen_d     = oen_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    regs_d    = regs_q;

    if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      phase_d = 1'b0;
      oen_d   = 1'b1;
      busy_d  = 1'b1;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      phase_d = 1'b0;
      oen_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            sr_d    = byte_in;
            rw_d    = sda_f;
            cnt_d   = last_bit ? '0 : cnt_q + BIT_CNT_W'(1);
            state_d = !last_bit ? ST_ADDR : (addr_match ? ST_ADDR_ACK : ST_WAIT);
          end else begin
            sr_d = sr_q;
          end
        end
        // First SCL fall drives ACK, second fall hands over to data phase.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              oen_d   = I2C_ACK;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              cnt_d   = '0;
              if (rw_q) begin
                sr_d    = rd_byte;
                oen_d   = rd_byte[7];
                state_d = ST_RDATA;
              end else begin
                oen_d   = 1'b1;
                state_d = ST_PTR;
              end
            end
          end else begin
            phase_d = phase_q;
          end
        end
        ST_PTR: begin
          if (scl_rise) begin
            sr_d    = byte_in;
            cnt_d   = last_bit ? '0 : cnt_q + BIT_CNT_W'(1);
            state_d = last_bit ? ST_PTR_ACK : ST_PTR;
          end else begin
            sr_d = sr_q;
          end
        end
        ST_PTR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              oen_d   = I2C_ACK;
              ptr_d   = sr_q[PTR_W-1:0];
              phase_d = 1'b1;
            end else begin
              oen_d   = 1'b1;
              phase_d = 1'b0;
              state_d = ST_WDATA;
            end
          end else begin
            phase_d = phase_q;
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            sr_d    = byte_in;
            cnt_d   = last_bit ? '0 : cnt_q + BIT_CNT_W'(1);
            state_d = last_bit ? ST_WDATA_ACK : ST_WDATA;
          end else begin
            sr_d = sr_q;
          end
        end
        // Register write, strobe and ACK drive all land on the same clock.
        ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              oen_d         = I2C_ACK;
              regs_d[ptr_q] = sr_q;
              wr_stb_d      = 1'b1;
              wr_addr_d     = 8'(ptr_q);
              wr_data_d     = sr_q;
              ptr_d         = ptr_q + PTR_W'(1);
              phase_d       = 1'b1;
            end else begin
              oen_d   = 1'b1;
              phase_d = 1'b0;
              state_d = ST_WDATA;
            end
          end else begin
            phase_d = phase_q;
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + BIT_CNT_W'(1);
          end else if (scl_fall) begin
            if (cnt_q == BIT_CNT_W'(8)) begin
              oen_d   = 1'b1;
              cnt_d   = '0;
              phase_d = 1'b0;
              state_d = ST_RDATA_MACK;
            end else begin
              sr_d  = {sr_q[6:0], 1'b1};
              oen_d = sr_q[6];
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        // Pointer has already advanced when the next byte is loaded on the fall.
        ST_RDATA_MACK: begin
          if (scl_rise) begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = (sda_f == I2C_NACK) ? ST_WAIT : ST_RDATA_MACK;
            phase_d = (sda_f == I2C_ACK);
          end else if (scl_fall && phase_q) begin
            phase_d = 1'b0;
            sr_d    = rd_byte;
            oen_d   = rd_byte[7];
            cnt_d   = '0;
            state_d = ST_RDATA;
          end else begin
            phase_d = phase_q;
          end
        end
        ST_IDLE, ST_WAIT: begin
          oen_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          oen_d   = 1'b1;
        end
      endcase
    end
  end

  // Protocol state, register file and registered pad/strobe outputs.
  always_ff @(posedge CLK_I or negedge ARST_N_I) begin
    if (!ARST_N_I) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sr_q       <= 8'h00;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      oen_q      <= 1'b1;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      oen_q      <= oen_d;
      busy_q     <= busy_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      regs_q     <= regs_d;
    end
  end

  assign SDA_PAD_O    = 1'b0;
  assign SDA_PADOEN_O = oen_q;
  assign BUSY_O       = busy_q;
  assign WR_STB_O     = wr_stb_q;
  assign WR_ADDR_O    = wr_addr_q;
  assign WR_DATA_O    = wr_data_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bit-banged I2C master bench with write/read scoreboards for i2c_slave_regfile.
module tb_i2c_slave_regfile;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  wire        sda_line;
  logic       sda_o, sda_oen, busy, wr_stb;
  logic [7:0] wr_addr, wr_data;

  int total = 0;
  int bad = 0;
  int stb_count = 0;
  bit oen_low_seen = 1'b0;
  bit stb_prev = 1'b0;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [15:0] mon_exp;

  assign sda_line = sda_m & (sda_oen | sda_o);

  always #5 clk = ~clk;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .NUM_REGS(16), .FILTER_LEN(3)) dut (
    .CLK_I       (clk),
    .ARST_N_I    (rst_n),
    .SCL_PAD_I   (scl_m),
    .SDA_PAD_I   (sda_line),
    .SDA_PAD_O   (sda_o),
    .SDA_PADOEN_O(sda_oen),
    .BUSY_O      (busy),
    .WR_STB_O    (wr_stb),
    .WR_ADDR_O   (wr_addr),
    .WR_DATA_O   (wr_data)
  );

  // Write-strobe scoreboard and SDA-drive observer.
  always @(negedge clk) begin
    if (sda_oen == 1'b0) oen_low_seen = 1'b1;
    if (wr_stb === 1'b1) begin
      stb_count++;
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected got=%h/%h required=none", wr_addr, wr_data);
      end else begin
        mon_exp = exp_wr.pop_front();
        if ({wr_addr, wr_data} !== mon_exp) begin
          bad++;
          $display("FAIL wr_beat got=%h/%h required=%h/%h", wr_addr, wr_data, mon_exp[15:8], mon_exp[7:0]);
        end
      end
      total++;
      if (stb_prev !== 1'b0) begin
        bad++;
        $display("FAIL wr_stb_width got=2+ cycles required=1");
      end
    end
    stb_prev = wr_stb;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic clk_bit(input logic b, output logic r);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(Q);
    r = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      d[i] = r;
    end
    clk_bit(mack, r);
  endtask

  task automatic xfer_write(input string name, input logic [7:0] ptr, input logic [31:0] data, input int n);
    logic ack;
    bus_start();
    send_byte(8'hA0, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL %s_addr_ack got=%b required=0", name, ack); end
    send_byte(ptr, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL %s_ptr_ack got=%b required=0", name, ack); end
    for (int i = 0; i < n; i++) begin
      send_byte(data[31-8*i -: 8], ack);
      total++;
      if (ack !== 1'b0) begin bad++; $display("FAIL %s_data%0d_ack got=%b required=0", name, i, ack); end
    end
  endtask

  task automatic xfer_read(input string name, input logic [7:0] ptr, input bit set_ptr, input int n);
    logic ack;
    logic [7:0] d, e;
    if (set_ptr) begin
      bus_start();
      send_byte(8'hA0, ack);
      total++;
      if (ack !== 1'b0) begin bad++; $display("FAIL %s_waddr_ack got=%b required=0", name, ack); end
      send_byte(ptr, ack);
      total++;
      if (ack !== 1'b0) begin bad++; $display("FAIL %s_ptr_ack got=%b required=0", name, ack); end
    end
    bus_start();
    send_byte(8'hA1, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL %s_raddr_ack got=%b required=0", name, ack); end
    for (int i = 0; i < n; i++) begin
      recv_byte(logic'(i == n - 1), d);
      total++;
      if (exp_rd.size() == 0) begin
        bad++;
        $display("FAIL %s_rd%0d got=%h required=none queued", name, i, d);
      end else begin
        e = exp_rd.pop_front();
        if (d !== e) begin bad++; $display("FAIL %s_rd%0d got=%h required=%h", name, i, d, e); end
      end
    end
  endtask

  task automatic test_reset();
    tick(3);
    total++;
    if ({sda_oen, sda_o, busy, wr_stb, wr_addr, wr_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL reset_outputs got=%b%b%b%b/%h/%h required=1000/00/00", sda_oen, sda_o, busy, wr_stb, wr_addr, wr_data);
    end
    rst_n = 1'b1;
    tick(20);
    total++;
    if ({sda_oen, busy} !== 2'b10) begin bad++; $display("FAIL reset_idle got=%b%b required=10", sda_oen, busy); end
  endtask

  task automatic test_write_read();
    int c0;
    c0 = stb_count;
    exp_wr.push_back({8'h03, 8'h5A});
    exp_wr.push_back({8'h04, 8'hC3});
    xfer_write("wr", 8'h03, {8'h5A, 8'hC3, 16'h0000}, 2);
    tick(Q);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy_mid got=%b required=1", busy); end
    bus_stop();
    tick(Q);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_after_stop got=%b required=0", busy); end
    total++;
    if (stb_count - c0 !== 2) begin bad++; $display("FAIL wr_stb_count got=%0d required=2", stb_count - c0); end
    exp_rd.push_back(8'h5A);
    exp_rd.push_back(8'hC3);
    xfer_read("rd", 8'h03, 1'b1, 2);
    bus_stop();
  endtask

  task automatic test_addr_mismatch();
    int c0;
    logic ack;
    c0 = stb_count;
    oen_low_seen = 1'b0;
    bus_start();
    send_byte(8'hA2, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL mis_addr_ack got=%b required=1", ack); end
    send_byte(8'h55, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL mis_data_ack got=%b required=1", ack); end
    bus_stop();
    tick(Q);
    total++;
    if (oen_low_seen !== 1'b0) begin bad++; $display("FAIL mis_oen_driven got=%b required=0", oen_low_seen); end
    total++;
    if (stb_count !== c0) begin bad++; $display("FAIL mis_stb got=%0d required=%0d", stb_count, c0); end
    bus_start();
    send_byte(8'hA0, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL mis_next_ack got=%b required=0", ack); end
    bus_stop();
  endtask

  task automatic test_wrap();
    int c0;
    c0 = stb_count;
    exp_wr.push_back({8'h0F, 8'h11});
    exp_wr.push_back({8'h00, 8'h22});
    xfer_write("wrap", 8'h0F, {8'h11, 8'h22, 16'h0000}, 2);
    bus_stop();
    total++;
    if (stb_count - c0 !== 2) begin bad++; $display("FAIL wrap_stb_count got=%0d required=2", stb_count - c0); end
    exp_rd.push_back(8'h11);
    exp_rd.push_back(8'h22);
    xfer_read("wrap_rd", 8'h0F, 1'b1, 2);
    bus_stop();
  endtask

  task automatic test_rstart_read();
    exp_wr.push_back({8'h05, 8'h35});
    exp_wr.push_back({8'h06, 8'h36});
    exp_wr.push_back({8'h07, 8'h37});
    exp_wr.push_back({8'h08, 8'h38});
    xfer_write("rs_wr", 8'h05, {8'h35, 8'h36, 8'h37, 8'h38}, 4);
    bus_stop();
    exp_rd.push_back(8'h35);
    exp_rd.push_back(8'h36);
    exp_rd.push_back(8'h37);
    xfer_read("rs", 8'h05, 1'b1, 3);
    tick(Q);
    total++;
    if ({sda_oen, busy} !== 2'b11) begin bad++; $display("FAIL rs_after_nack got=%b%b required=11", sda_oen, busy); end
    bus_stop();
    tick(Q);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rs_busy_stop got=%b required=0", busy); end
    exp_rd.push_back(8'h38);
    xfer_read("rs_ptr", 8'h00, 1'b0, 1);
    bus_stop();
  endtask

  task automatic test_glitch();
    tick(Q);
    sda_m = 1'b0;
    tick(2);
    sda_m = 1'b1;
    tick(20);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL glitch_start got=%b required=0", busy); end
  endtask

  task automatic test_reset_midread();
    logic ack;
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h03, ack);
    bus_start();
    send_byte(8'hA1, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL rst_raddr_ack got=%b required=0", ack); end
    total++;
    if (sda_oen !== 1'b0) begin bad++; $display("FAIL rst_msb_drive got=%b required=0", sda_oen); end
    rst_n = 1'b0;
    #1;
    total++;
    if (sda_oen !== 1'b1) begin bad++; $display("FAIL rst_async_release got=%b required=1", sda_oen); end
    tick(3);
    rst_n = 1'b1;
    tick(3);
    bus_stop();
    for (int i = 0; i < 16; i++) exp_rd.push_back(8'h00);
    xfer_read("rst_clear", 8'h00, 1'b1, 16);
    bus_stop();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_addr_mismatch();
    test_wrap();
    test_rstart_read();
    test_glitch();
    test_reset_midread();
    tick(Q);
    total++;
    if (exp_wr.size() != 0) begin bad++; $display("FAIL wr_missing got=%0d pending required=0", exp_wr.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
